// File: rtl/seq_detector_param.sv
// Serial pattern detector: pulses `out` when the last len valid bits equal a programmable pattern.
// Latency: out, match_cnt and busy are registered and update on the edge that consumes the final bit.
// Backpressure: none; the block accepts every qualified bit, and in_valid=0 simply holds all state.
module seq_detector_param #(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(4'b1001),
  // Derived from PAT_W; leave at its default.
  parameter int               LEN_W   = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Registered state
  logic [PAT_W-1:0] history_q, history_d;
  logic [LEN_W-1:0] fill_q,    fill_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0] len_q,     len_d;
  logic             overlap_q, overlap_d;
  logic             out_q,     out_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             busy_q,    busy_d;

  // Intermediate combinational values
  logic [LEN_W-1:0] cfg_len_clamped;
  logic [PAT_W-1:0] len_mask;
  logic [PAT_W-1:0] history_shift;
  logic [LEN_W-1:0] fill_inc;
  logic             hit;

  // Clamp the requested length into 1..PAT_W so the compare mask is never empty or oversized.
  always_comb begin
    cfg_len_clamped = cfg_len;
    if (cfg_len == '0) begin
      cfg_len_clamped = LEN_W'(1);
    end else if (cfg_len > LEN_MAX) begin
      cfg_len_clamped = LEN_MAX;
    end
  end

  // Mask selecting the low len_q history bits; bits above the active length never participate.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
  end

  // Candidate next history/fill if the current bit is consumed, and the match decision on it.
  // The concatenate-then-truncate form keeps the shift legal even for PAT_W == 1.
  always_comb begin
    history_shift = PAT_W'({history_q, in});
    fill_inc      = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_W'(1);
    hit           = (fill_inc >= len_q) &&
                    ((history_shift & len_mask) == (pattern_q & len_mask));
  end

  // Next-state for config, history, fill and the match pulse; a config load wins over a data bit.
  always_comb begin
    history_d = history_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    out_d     = 1'b0;
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = cfg_len_clamped;
      overlap_d = cfg_overlap;
      history_d = '0;
      fill_d    = '0;
    end else if (in_valid) begin
      history_d = history_shift;
      fill_d    = fill_inc;
      if (hit) begin
        out_d = 1'b1;
        // Non-overlapping mode forces the next match to be built from len fresh bits.
        if (!overlap_q) begin
          fill_d = '0;
        end
      end
    end
  end

  // Saturating match counter; a clear overrides a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // busy follows the registered fill count, so it is computed from fill_d.
  always_comb begin
    busy_d = (fill_d != '0);
  end

  // State register with asynchronous reset to the default configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      history_q <= '0;
      fill_q    <= '0;
      pattern_q <= DEF_PAT;
      len_q     <= LEN_MAX;
      overlap_q <= 1'b1;
      out_q     <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      history_q <= history_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      out_q     <= out_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign out       = out_q;
  assign match_cnt = cnt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Testbench for seq_detector_param: directed plan scenarios plus random traffic.
// Every cycle's expected out/match_cnt/busy is queued by the driver and checked by a monitor.
// The DUT never stalls; the bench drives one input set per clock.
module tb_seq_detector_param;

  localparam int PAT_W = 4;
  localparam int CNT_W = 2;
  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             cfg_load = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic             cnt_clr = 1'b0;
  logic             out;
  logic [CNT_W-1:0] match_cnt;
  logic             busy;

  seq_detector_param #(
    .PAT_W  (PAT_W),
    .CNT_W  (CNT_W),
    .DEF_PAT(4'b1001)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in         (in_bit),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .cnt_clr    (cnt_clr),
    .out        (out),
    .match_cnt  (match_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             out;
    logic [CNT_W-1:0] cnt;
    logic             busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   pulses   = 0;

  // Reference model: list of received bits, fresh-bit count and stored configuration.
  bit               m_bits[$];
  int               m_fresh;
  logic [PAT_W-1:0] m_pat;
  int               m_len;
  bit               m_ovl;
  int               m_cnt;

  task automatic model_reset();
    m_bits.delete();
    m_fresh = 0;
    m_pat   = 4'b1001;
    m_len   = PAT_W;
    m_ovl   = 1'b1;
    m_cnt   = 0;
  endtask

  // Pattern bit [len-1] is the oldest of the last len bits, bit [0] the newest.
  function automatic bit model_match();
    int n;
    n = m_bits.size();
    if (m_fresh < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      if (m_bits[n-1-k] != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Apply one cycle of inputs, update the model at the edge and queue the expected outputs.
  task automatic step(input bit v, input bit b, input bit ld = 1'b0,
                      input logic [PAT_W-1:0] pat = '0, input int len = 0,
                      input bit ovl = 1'b0, input bit clr = 1'b0);
    bit   m_out;
    int   l;
    exp_t e;
    in_valid    = v;
    in_bit      = b;
    cfg_load    = ld;
    cfg_pattern = pat;
    cfg_len     = LEN_W'(len);
    cfg_overlap = ovl;
    cnt_clr     = clr;
    @(posedge clk);
    m_out = 1'b0;
    if (ld) begin
      l = len;
      if (l == 0) l = 1;
      if (l > PAT_W) l = PAT_W;
      m_pat   = pat;
      m_len   = l;
      m_ovl   = ovl;
      m_bits.delete();
      m_fresh = 0;
    end else if (v) begin
      m_bits.push_back(b);
      if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
      if (m_fresh < PAT_W) m_fresh++;
      if (model_match()) begin
        m_out = 1'b1;
        if (!m_ovl) m_fresh = 0;
      end
    end
    if (clr) m_cnt = 0;
    else if (m_out && m_cnt < CNT_MAX) m_cnt++;
    e.out  = m_out;
    e.cnt  = CNT_W'(m_cnt);
    e.busy = (m_fresh != 0);
    exp_q.push_back(e);
    #2;
  endtask

  task automatic bit_in(input bit b);
    step(1'b1, b);
  endtask

  task automatic cfg(input logic [PAT_W-1:0] pat, input int len, input bit ovl, input bit clr = 1'b0);
    step(1'b0, 1'b0, 1'b1, pat, len, ovl, clr);
  endtask

  // Asynchronous reset asserted away from the clock edge; outputs must clear immediately.
  task automatic do_reset();
    in_valid = 1'b0;
    cfg_load = 1'b0;
    cnt_clr  = 1'b0;
    rst      = 1'b1;
    #1;
    chk("rst_out", int'(out), 0);
    chk("rst_cnt", int'(match_cnt), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: one observation per clock, compared against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({out, match_cnt, busy} !== e) begin
          failures++;
          $display("FAIL cycle_out t=%0t: out=%b cnt=%0d busy=%b expected out=%b cnt=%0d busy=%b",
                   $time, out, match_cnt, busy, e.out, e.cnt, e.busy);
        end
      end
      if (out === 1'b1) pulses++;
    end
  end

  initial begin
    int p0;
    int wait_cycles;
    int seq1[7];
    int seq4[4];
    int cnt_seq[5];
    seq1    = '{1, 0, 0, 1, 0, 0, 1};
    seq4    = '{1, 0, 0, 1};
    cnt_seq = '{1, 2, 3, 3, 3};

    model_reset();
    do_reset();

    // Default pattern 1001, overlapping.
    p0 = pulses;
    foreach (seq1[i]) bit_in(seq1[i][0]);
    chk("ovl_pulses", pulses - p0, 2);
    chk("ovl_cnt", int'(match_cnt), 2);

    // Same pattern, non-overlapping; counter cleared alongside the load.
    cfg(4'b1001, 4, 1'b0, 1'b1);
    p0 = pulses;
    foreach (seq1[i]) bit_in(seq1[i][0]);
    chk("novl_pulses", pulses - p0, 1);
    chk("novl_cnt", int'(match_cnt), 1);

    // Pattern 11 of length 2, overlapping then non-overlapping.
    cfg(4'b0011, 2, 1'b1);
    p0 = pulses;
    repeat (4) bit_in(1'b1);
    chk("p11_ovl_pulses", pulses - p0, 3);
    cfg(4'b0011, 2, 1'b0);
    p0 = pulses;
    repeat (4) bit_in(1'b1);
    chk("p11_novl_pulses", pulses - p0, 2);

    // Gaps of three idle cycles between valid bits are transparent.
    cfg(4'b1001, 4, 1'b1);
    p0 = pulses;
    foreach (seq4[i]) begin
      bit_in(seq4[i][0]);
      if (i < 3) repeat (3) step(1'b0, 1'b1);
    end
    chk("gap_pulses", pulses - p0, 1);

    // Length-1 pattern '1': counter saturates at 3, then clear beats the increment.
    cfg(4'b0001, 1, 1'b1, 1'b1);
    foreach (cnt_seq[i]) begin
      bit_in(1'b1);
      chk("sat_cnt", int'(match_cnt), cnt_seq[i]);
    end
    step(1'b1, 1'b1, 1'b0, '0, 0, 1'b0, 1'b1);
    chk("clr_cnt", int'(match_cnt), 0);
    chk("clr_out", int'(out), 1);

    // Reset mid-sequence discards history.
    do_reset();
    bit_in(1'b1);
    bit_in(1'b0);
    bit_in(1'b0);
    do_reset();
    p0 = pulses;
    bit_in(1'b1);
    chk("post_rst_pulses", pulses - p0, 0);
    chk("post_rst_cnt", int'(match_cnt), 0);

    // Config load with len=0 and a simultaneous data bit: bit dropped, length clamps to 1.
    step(1'b1, 1'b1, 1'b1, 4'b0001, 0, 1'b1);
    chk("ld_drop_out", int'(out), 0);
    chk("ld_drop_busy", int'(busy), 0);
    bit_in(1'b1);
    chk("len0_out", int'(out), 1);

    // Random traffic including occasional reconfiguration (lengths beyond PAT_W) and clears.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(99) < 2) begin
        step(1'b1, 1'($urandom), 1'b1, PAT_W'($urandom), $urandom_range((1 << LEN_W) - 1),
             1'($urandom), ($urandom_range(3) == 0));
      end else begin
        step(($urandom_range(99) < 70), 1'($urandom), 1'b0, '0, 0, 1'b0,
             ($urandom_range(99) < 3));
      end
    end
    in_valid = 1'b0;
    cnt_clr  = 1'b0;

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #3;
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parameterised serial pattern detector, successor to the fixed 1001 detector. It watches a gated serial bit stream and pulses `out` for one cycle each time the last pat_len bits match a run-time programmable pattern. Overlapping or non-overlapping detection is selectable, and a saturating match counter is provided. It sits between a serial front-end (deserialiser or bit-sampler) and control or status logic.

Parameters:
PAT_W, 4, maximum pattern length in bits (>=1)
CNT_W, 8, match counter width (>=1)
DEF_PAT, 4'b1001 (PAT_W bits), pattern loaded at reset
LEN_W, $clog2(PAT_W+1), width of pat_len (derived, not overridden)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  qualifies `in`; bit is consumed only when high
in  input  1  serial data bit
cfg_load  input  1  one-cycle strobe; latch cfg_pattern/cfg_len/cfg_overlap
cfg_pattern  input  PAT_W  new pattern; bit [len-1] is the first bit received, bit [0] the last
cfg_len  input  LEN_W  new active length; 0 is treated as 1, >PAT_W clamps to PAT_W
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
cnt_clr  input  1  synchronous clear of match_cnt
out  output  1  registered one-cycle match pulse
match_cnt  output  CNT_W  saturating count of matches
busy  output  1  high while fill count > 0 (a partial sequence is being tracked)

Behaviour:
- Reset (async, any time):
  - history=0, fill=0, out=0, match_cnt=0, busy=0.
  - Stored pattern=DEF_PAT, len=PAT_W, overlap=1.
  - Reset mid-sequence discards all partial history.
- State:
  - history: PAT_W-bit shift register; new bit enters at [0].
  - fill: saturating 0..PAT_W count of valid bits since the last clear.
  - Stored config registers: pattern, len, overlap.
- Bit consumption (in_valid=1, cfg_load=0), at the edge:
  - history <= {history[PAT_W-2:0], in}; fill <= min(fill+1, PAT_W).
  - Match when fill_next >= len AND history_next[len-1:0] == pattern[len-1:0]. Compare only the low len bits; bits above len are ignored.
- Match:
  - out=1 for exactly the cycle following the consuming edge (registered, zero extra latency: visible right after the edge that sampled the last bit).
  - match_cnt increments, saturating at 2^CNT_W-1.
  - overlap=1: history and fill are kept, so a suffix can start the next match.
  - overlap=0: fill <= 0 on that edge, so the next match needs len fresh bits.
- in_valid=0: history, fill and config hold; out=0. Gaps of any length are transparent.
- cfg_load=1:
  - Latch the clamped config, history<=0, fill<=0, out<=0.
  - A simultaneous in_valid bit is discarded (config wins).
  - match_cnt is unaffected.
- cnt_clr=1: match_cnt<=0. It beats a simultaneous increment (count ends at 0), but out still pulses for that match.
- busy = (fill != 0), registered.
- No internal FSM beyond fill and history. The equivalent Moore states are "fill k, history h"; the bench checks against a reference model, not state encodings.

Test Plan:
- Default config after reset, overlap=1, stream 1,0,0,1,0,0,1 (all valid) -> out pulses after bits 4 and 7; match_cnt=2.
- cfg_overlap=0, same pattern and stream -> single pulse after bit 4 (bits 5-7 give only 3 fresh bits); match_cnt=1.
- cfg_pattern=2'b11, cfg_len=2, overlap=1, stream 1,1,1,1 -> pulses after bits 2,3,4; repeat with overlap=0 -> pulses after bits 2 and 4 only.
- Stream 1,0,0,1 with in_valid low for 3 cycles between every bit -> one pulse after the 4th valid bit; out=0 during gaps.
- CNT_W=2, pattern len=1 value 1, five valid 1s -> match_cnt 1,2,3,3,3. cnt_clr asserted together with a 6th match -> match_cnt=0, out=1.
- Stream 1,0,0, then rst pulse, then 1 -> no pulse, match_cnt=0, busy=0 during reset. Then cfg_load with cfg_len=0 and cfg_pattern bit0=1, plus in=1 in the same cycle -> bit ignored, next single 1 pulses (len clamped to 1).
